ps_gaussian_mac: RTL and testbench

Pipelined 3x3 Gaussian filter stage that consumes the three 3-pixel row windows produced by the line-buffer kernel controller. It emits one filtered pixel per valid window. It tracks output column and line position so the downstream frame writer gets end-of-line and end-of-frame markers. Full throughput: one window accepted per clock, no backpressure.

---
 rtl/ps_gaussian_mac.sv | 104 ++++++++++
 tb/tb_ps_gaussian_mac.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_gaussian_mac.sv
// ps_gaussian_mac: 3x3 Gaussian [1 2 1; 2 4 2; 1 2 1]/16 filter with end-of-line/end-of-frame markers.
// Latency: 3 cycles from an accepted window to o_valid/o_data; one window per clock sustained.
// Backpressure: none; every i_valid window is accepted and the block never stalls upstream.
module ps_gaussian_mac #(
  parameter int LINE_LENGTH = 640,
  parameter int LINE_COUNT  = 480,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [3*DATA_WIDTH-1:0]   i_r0_data,
  input  logic [3*DATA_WIDTH-1:0]   i_r1_data,
  input  logic [3*DATA_WIDTH-1:0]   i_r2_data,
  input  logic                      i_valid,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic                      o_valid,
  output logic                      o_eol,
  output logic                      o_eof
);

  localparam int SUM_W = DATA_WIDTH + 2;
  localparam int TOT_W = DATA_WIDTH + 4;
  localparam int COL_W = $clog2(LINE_LENGTH) + 1;
  localparam int LIN_W = $clog2(LINE_COUNT) + 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LENGTH - 1);
  localparam logic [LIN_W-1:0] LIN_LAST = LIN_W'(LINE_COUNT - 1);

  // Horizontal [1 2 1] weighting of one 3-pixel row window.
  function automatic logic [SUM_W-1:0] row_sum(input logic [3*DATA_WIDTH-1:0] w);
    logic [SUM_W-1:0] left;
    logic [SUM_W-1:0] mid;
    logic [SUM_W-1:0] right;
    left  = SUM_W'(w[0 +: DATA_WIDTH]);
    mid   = {1'b0, w[DATA_WIDTH +: DATA_WIDTH], 1'b0};
    right = SUM_W'(w[2*DATA_WIDTH +: DATA_WIDTH]);
    return left + mid + right;
  endfunction

  logic [2:0]            vld_pipe;
  logic [SUM_W-1:0]      s0_dat;
  logic [SUM_W-1:0]      s1_dat;
  logic [SUM_W-1:0]      s2_dat;
  logic [TOT_W-1:0]      tot_dat;
  logic [TOT_W:0]        rounded;
  logic [TOT_W:0]        shifted;
  logic [DATA_WIDTH-1:0] scaled;
  logic [COL_W-1:0]      col_cnt;
  logic [LIN_W-1:0]      line_cnt;

  // Valid shift register: o_valid is i_valid delayed by exactly three clocks.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) vld_pipe <= '0;
    else         vld_pipe <= {vld_pipe[1:0], i_valid};
  end

  // Stage 1: per-row horizontal sums, loaded only for valid windows.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      s0_dat <= '0;
      s1_dat <= '0;
      s2_dat <= '0;
    end else if (i_valid) begin
      s0_dat <= row_sum(i_r0_data);
      s1_dat <= row_sum(i_r1_data);
      s2_dat <= row_sum(i_r2_data);
    end
  end

  // Stage 2: vertical [1 2 1] combination of the row sums.
  always_ff @(posedge i_clk) begin
    if (!i_rstn)          tot_dat <= '0;
    else if (vld_pipe[0]) tot_dat <= TOT_W'(s0_dat) + {1'b0, s1_dat, 1'b0} + TOT_W'(s2_dat);
  end

  // Round half up, divide by 16; the saturation branch guards against any width overflow.
  always_comb begin
    rounded = {1'b0, tot_dat} + (TOT_W+1)'(8);
    shifted = rounded >> 4;
    scaled  = (|shifted[TOT_W:DATA_WIDTH]) ? '1 : shifted[DATA_WIDTH-1:0];
  end

  // Stage 3: output pixel register, holds its value between valid results.
  always_ff @(posedge i_clk) begin
    if (!i_rstn)          o_data <= '0;
    else if (vld_pipe[1]) o_data <= scaled;
  end

  assign o_valid = vld_pipe[2];
  assign o_eol   = o_valid && (col_cnt == COL_LAST);
  assign o_eof   = o_eol && (line_cnt == LIN_LAST);

  // Output column position, advancing only on emitted pixels and wrapping at end of line.
  always_ff @(posedge i_clk) begin
    if (!i_rstn)      col_cnt <= '0;
    else if (o_valid) col_cnt <= o_eol ? '0 : col_cnt + COL_W'(1);
  end

  // Output line position, advancing at each end of line and wrapping after the frame's last pixel.
  always_ff @(posedge i_clk) begin
    if (!i_rstn)    line_cnt <= '0;
    else if (o_eol) line_cnt <= o_eof ? '0 : line_cnt + LIN_W'(1);
  end

endmodule

// File: tb/tb_ps_gaussian_mac.sv
// tb_ps_gaussian_mac: directed and random stimulus with a scoreboard of expected pixels and markers.
// Expected values come from constants or a direct 2-D kernel model; latency is checked per pixel.
// All stimulus and checking run in one process: inputs change #1 after posedge, outputs sampled on negedge.
`timescale 1ns/1ps
module tb_ps_gaussian_mac;

  localparam int L  = 4;
  localparam int C  = 2;
  localparam int DW = 8;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic [3*DW-1:0] i_r0_data = '0;
  logic [3*DW-1:0] i_r1_data = '0;
  logic [3*DW-1:0] i_r2_data = '0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_eol;
  logic          o_eof;

  ps_gaussian_mac #(.LINE_LENGTH(L), .LINE_COUNT(C), .DATA_WIDTH(DW)) dut (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_r0_data (i_r0_data),
    .i_r1_data (i_r1_data),
    .i_r2_data (i_r2_data),
    .i_valid   (i_valid),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_eol     (o_eol),
    .o_eof     (o_eof)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          eol;
    logic          eof;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            m_col   = 0;
  int            m_line  = 0;
  int            n_eol   = 0;
  int            n_eof   = 0;
  logic [DW-1:0] last_data = '0;
  bit            mon_on  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: full 2-D kernel weights applied to the nine pixels, round half up, divide by 16.
  function automatic logic [DW-1:0] gauss(input logic [3*DW-1:0] r0, input logic [3*DW-1:0] r1,
                                          input logic [3*DW-1:0] r2);
    logic [3*DW-1:0] rows [3];
    int k [3];
    int acc;
    rows[0] = r0; rows[1] = r1; rows[2] = r2;
    k[0] = 1; k[1] = 2; k[2] = 1;
    acc = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += k[i] * k[j] * int'(rows[i][j*DW +: DW]);
    acc = (acc + 8) / 16;
    if (acc > 255) acc = 255;
    return DW'(acc);
  endfunction

  function automatic logic [3*DW-1:0] uni(input logic [DW-1:0] v);
    return {v, v, v};
  endfunction

  // Output-side checks for the cycle just completed.
  task automatic monitor();
    exp_t e;
    if (!mon_on) return;
    if (o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(o_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("latency", 32'(cyc), 32'(e.due));
        check("data", 32'(o_data), 32'(e.data));
        check("eol", 32'(o_eol), 32'(e.eol));
        check("eof", 32'(o_eof), 32'(e.eof));
        last_data = e.data;
      end
      if (o_eol === 1'b1) n_eol++;
      if (o_eof === 1'b1) n_eof++;
    end else begin
      check("valid_low", 32'(o_valid), 32'd0);
      check("eol_idle", 32'(o_eol), 32'd0);
      check("eof_idle", 32'(o_eof), 32'd0);
      check("data_hold", 32'(o_data), 32'(last_data));
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    monitor();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic scramble();
    i_r0_data = 24'($urandom);
    i_r1_data = 24'($urandom);
    i_r2_data = 24'($urandom);
  endtask

  task automatic send(input logic [3*DW-1:0] r0, input logic [3*DW-1:0] r1,
                      input logic [3*DW-1:0] r2, input logic [DW-1:0] exp_data);
    exp_t e;
    i_valid = 1'b1;
    i_r0_data = r0; i_r1_data = r1; i_r2_data = r2;
    e.data = exp_data;
    e.eol  = (m_col == L - 1);
    e.eof  = e.eol && (m_line == C - 1);
    e.due  = cyc + 3;
    sb.push_back(e);
    if (e.eol) begin
      m_col  = 0;
      m_line = e.eof ? 0 : m_line + 1;
    end else begin
      m_col++;
    end
    tick();
    i_valid = 1'b0;
    scramble();
  endtask

  task automatic send_rand();
    logic [3*DW-1:0] a, b, c;
    a = 24'($urandom); b = 24'($urandom); c = 24'($urandom);
    send(a, b, c, gauss(a, b, c));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drain(input string tag);
    idle(6);
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset(input int n);
    i_rstn = 1'b0;
    i_valid = 1'b0;
    scramble();
    repeat (n) tick();
    sb.delete();
    m_col = 0;
    m_line = 0;
    last_data = '0;
    i_rstn = 1'b1;
  endtask

  initial begin
    @(posedge i_clk);
    #1;
    // Reset state.
    do_reset(2);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_eol", 32'(o_eol), 32'd0);
    check("rst_eof", 32'(o_eof), 32'd0);
    mon_on = 1'b1;

    // Uniform field, single window.
    send(uni(8'd100), uni(8'd100), uni(8'd100), 8'd100);
    drain("drain_uniform");

    // Impulses and saturating-looking full-scale input.
    send(24'h00FF00 >> 0 & 24'h0, 24'h00FF00, 24'h0, 8'd64);
    send(24'h0000FF, 24'h0, 24'h0, 8'd16);
    send(uni(8'd255), uni(8'd255), uni(8'd255), 8'd255);
    drain("drain_impulse");

    // Gapped input: 1,0,0,1,1 with uniform values 10,20,30.
    send(uni(8'd10), uni(8'd10), uni(8'd10), 8'd10);
    idle(2);
    send(uni(8'd20), uni(8'd20), uni(8'd20), 8'd20);
    send(uni(8'd30), uni(8'd30), uni(8'd30), 8'd30);
    drain("drain_gap");
    check("gap_final_hold", 32'(o_data), 32'd30);

    // Framing: two full 4x2 frames from a clean start.
    do_reset(1);
    n_eol = 0;
    n_eof = 0;
    for (int i = 0; i < 2 * L * C; i++) begin
      logic [DW-1:0] v;
      v = DW'(i * 13 + 5);
      send(uni(v), uni(v), uni(v), v);
    end
    drain("drain_frame");
    check("frame_eol_count", 32'(n_eol), 32'd4);
    check("frame_eof_count", 32'(n_eof), 32'd2);

    // Reset with two windows in flight: neither may emerge.
    send(uni(8'd77), uni(8'd77), uni(8'd77), 8'd77);
    send(uni(8'd88), uni(8'd88), uni(8'd88), 8'd88);
    do_reset(1);
    check("midrst_data", 32'(o_data), 32'd0);
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_eol", 32'(o_eol), 32'd0);
    check("midrst_eof", 32'(o_eof), 32'd0);
    idle(5);
    n_eol = 0;
    n_eof = 0;
    for (int i = 0; i < L; i++) send(uni(8'd50), uni(8'd50), uni(8'd50), 8'd50);
    drain("drain_after_rst");
    check("after_rst_eol_count", 32'(n_eol), 32'd1);

    // Random streaming: three frames at full rate, then two frames with random gaps.
    do_reset(1);
    n_eol = 0;
    n_eof = 0;
    for (int i = 0; i < 3 * L * C; i++) send_rand();
    for (int i = 0; i < 2 * L * C; i++) begin
      send_rand();
      idle($urandom_range(0, 2));
    end
    drain("drain_stream");
    check("stream_eol_count", 32'(n_eol), 32'(5 * C));
    check("stream_eof_count", 32'(n_eof), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
